pair_chain_checker: RTL and testbench
=====================================

PAIR_CHAIN_CHECKER -- requirements
Module: pair_chain_checker

Interface
REQ-001 The block SHALL have parameter IO_PAIRS, default 4, giving the number of (odd,even) bit pairs in the checked vector.
REQ-002 The block SHALL have parameter DEPTH, default 1, giving the number of pair-transform stages in the circuit under test.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the vector and error counters.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: single-cycle pulse that begins a check run.
REQ-007 The block SHALL have port num_vec, input, CNT_W bits: number of vectors in a run, sampled when start is accepted.
REQ-008 The block SHALL have port stim_valid, input, 1 bit: stim and resp hold a valid pair.
REQ-009 The block SHALL have port stim_ready, output, 1 bit: checker accepts a pair this cycle.
REQ-010 The block SHALL have port stim, input, 2*IO_PAIRS bits: vector applied to the circuit under test.
REQ-011 The block SHALL have port resp, input, 2*IO_PAIRS bits: circuit-under-test output for stim, same cycle.
REQ-012 The block SHALL have port vec_cnt, output, CNT_W bits: number of vectors compared so far.
REQ-013 The block SHALL have port err_cnt, output, CNT_W bits: number of mismatching vectors.
REQ-014 The block SHALL have port done, output, 1 bit: run complete.
REQ-015 The block SHALL have port pass, output, 1 bit: run complete with err_cnt == 0.
REQ-016 The block SHALL have port first_fail, output, 2*IO_PAIRS bits, present only with CHK_FIRST_FAIL_EN: stim of the first mismatch.

Function
REQ-017 Expected response model per pair j, applied DEPTH times: odd' = odd ^ even; even' = ~even; stage k output feeds stage k+1.
REQ-018 FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start -> RUN; vec_cnt, err_cnt and the capture register are cleared; num_vec is latched.
- RUN + accepted count == latched num_vec -> DRAIN.
- DRAIN + pipeline empty -> DONE.
REQ-019 start while in RUN or DRAIN SHALL be ignored.
REQ-020 stim_ready SHALL be 1 only in RUN while accepted count < latched num_vec; a transfer occurs when stim_valid && stim_ready.
REQ-021 Pipeline: stage 1 registers stim, resp and the expected value; stage 2 compares and updates the counters.
- vec_cnt and err_cnt SHALL reflect a transfer exactly 2 cycles after its accepting edge.
- Back-to-back transfers SHALL sustain 1 vector per cycle.
REQ-022 A mismatch is any bit difference between resp and expected; err_cnt increments by 1 per mismatching vector.
REQ-023 err_cnt SHALL saturate at 2^CNT_W-1; vec_cnt never exceeds latched num_vec.
REQ-024 num_vec == 0 at start SHALL go RUN -> DRAIN -> DONE with no transfers and pass = 1.
REQ-025 done and pass SHALL be registered and change only on entry to DONE or on leaving it.
REQ-026 pass = done && (err_cnt == 0).

Reset
REQ-027 rst_n low SHALL asynchronously force the following, including mid-run: IDLE, stim_ready = 0, done = 0, pass = 0, vec_cnt = 0, err_cnt = 0, first_fail = 0, and pipeline valid bits cleared.
REQ-028 After rst_n rises, the block SHALL accept no transfer before a start pulse.

Configuration
REQ-029 Macro CHK_FIRST_FAIL_EN: when defined, the block SHALL provide first_fail, loaded with stim of the first mismatching vector of a run and held until the next start or reset; when undefined, the port and its register SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 IO_PAIRS=4, DEPTH=1, num_vec=2, stim 8'h00/resp 8'h55 then 8'hFF/resp 8'h00 -> err_cnt=0, vec_cnt=2, done=1, pass=1.
REQ-031 Same parameters, stim 8'h01 with resp 8'h55 (expected 8'h56), num_vec=1 -> err_cnt=1, pass=0, first_fail=8'h01 (macro defined).
REQ-032 Run num_vec=8 with continuous stim_valid -> 8 transfers in 8 consecutive cycles; vec_cnt=8 two cycles after the last transfer.
REQ-033 Assert rst_n low after 3 of 8 vectors -> all outputs 0 immediately; a new start begins a clean run.
REQ-034 num_vec=0 start -> done=1, pass=1, stim_ready never asserted.
REQ-035 DEPTH=2, stim 8'h00 -> expected 8'hAA (every pair odd=1, even=0); matching resp gives pass=1.

Source files
------------

// File: rtl/pair_chain_checker.sv
// pair_chain_checker: streams (stim,resp) pairs through a 2-stage compare pipeline against a DEPTH-stage pair-transform model.
// Optional first_fail capture is built when CHK_FIRST_FAIL_EN is defined.
module pair_chain_checker #(
  parameter int IO_PAIRS = 4,
  parameter int DEPTH    = 1,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_vec,
  input  logic                  stim_valid,
  output logic                  stim_ready,
  input  logic [2*IO_PAIRS-1:0] stim,
  input  logic [2*IO_PAIRS-1:0] resp,
  output logic [CNT_W-1:0]      vec_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  done,
  output logic                  pass
`ifdef CHK_FIRST_FAIL_EN
  ,
  output logic [2*IO_PAIRS-1:0] first_fail
`endif
);
  localparam int W = 2 * IO_PAIRS;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d, acc_q, acc_d, vec_q, vec_d, err_q, err_d;
  logic done_q, done_d, pass_q, pass_d;
  logic v1_q, v2_q, mis2_q;
  logic [W-1:0] stim1_q, resp1_q, exp1_q;
  logic start_ok, xfer;
  // Pair j occupies bits {2j+1 (odd), 2j (even)}
  function automatic logic [W-1:0] model(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int k = 0; k < DEPTH; k++)
      for (int j = 0; j < IO_PAIRS; j++) begin
        r[2*j+1] = r[2*j+1] ^ r[2*j];
        r[2*j]   = ~r[2*j];
      end
    return r;
  endfunction
  assign start_ok   = start && (state_q == IDLE || state_q == DONE);
  assign stim_ready = (state_q == RUN) && (acc_q < num_q);
  assign xfer       = stim_valid && stim_ready;
  assign vec_cnt    = vec_q;
  assign err_cnt    = err_q;
  assign done       = done_q;
  assign pass       = pass_q;
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    acc_d   = acc_q;
    vec_d   = vec_q;
    err_d   = err_q;
    done_d  = done_q;
    pass_d  = pass_q;
    if (start_ok) begin
      state_d = RUN;
      num_d   = num_vec;
      acc_d   = '0;
      vec_d   = '0;
      err_d   = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      if (xfer) acc_d = acc_q + CNT_W'(1);
      if (v2_q) begin
        vec_d = vec_q + CNT_W'(1);
        if (mis2_q && err_q != '1) err_d = err_q + CNT_W'(1);
      end
      if (state_q == RUN && acc_q == num_q) state_d = DRAIN;
      // Counters are final once both pipeline stages are empty
      if (state_q == DRAIN && !v1_q && !v2_q) begin
        state_d = DONE;
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      acc_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      mis2_q  <= 1'b0;
      stim1_q <= '0;
      resp1_q <= '0;
      exp1_q  <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      acc_q   <= acc_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      v1_q    <= xfer;
      v2_q    <= v1_q;
      mis2_q  <= resp1_q != exp1_q;
      if (xfer) begin
        stim1_q <= stim;
        resp1_q <= resp;
        exp1_q  <= model(stim);
      end
    end
  end
`ifdef CHK_FIRST_FAIL_EN
  logic [W-1:0] stim2_q, ff_q;
  assign first_fail = ff_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim2_q <= '0;
      ff_q    <= '0;
    end else begin
      stim2_q <= stim1_q;
      if (start_ok) ff_q <= '0;
      else if (v2_q && mis2_q && err_q == '0) ff_q <= stim2_q;
    end
  end
`endif
endmodule

// File: tb/tb_pair_chain_checker.sv
// tb_pair_chain_checker: directed checks of pair_chain_checker at DEPTH=1 and DEPTH=2.
module tb_pair_chain_checker;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start1 = 1'b0, valid1 = 1'b0, ready1, done1, pass1;
  logic [15:0] num1 = '0, vec1, err1;
  logic [7:0] stim1 = '0, resp1 = '0;
  logic start2 = 1'b0, valid2 = 1'b0, ready2, done2, pass2;
  logic [15:0] num2 = '0, vec2, err2;
  logic [7:0] stim2 = '0, resp2 = '0;
`ifdef CHK_FIRST_FAIL_EN
  logic [7:0] ff1, ff2;
`endif
  int vectors = 0, miscompares = 0;

  pair_chain_checker #(.IO_PAIRS(4), .DEPTH(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .num_vec(num1),
    .stim_valid(valid1), .stim_ready(ready1), .stim(stim1), .resp(resp1),
    .vec_cnt(vec1), .err_cnt(err1), .done(done1), .pass(pass1)
`ifdef CHK_FIRST_FAIL_EN
    , .first_fail(ff1)
`endif
  );
  pair_chain_checker #(.IO_PAIRS(4), .DEPTH(2), .CNT_W(16)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .num_vec(num2),
    .stim_valid(valid2), .stim_ready(ready2), .stim(stim2), .resp(resp2),
    .vec_cnt(vec2), .err_cnt(err2), .done(done2), .pass(pass2)
`ifdef CHK_FIRST_FAIL_EN
    , .first_fail(ff2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run1(input logic [15:0] n);
    num1 = n;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] s, input logic [7:0] r, output bit ok);
    valid1 = 1'b1;
    stim1 = s;
    resp1 = r;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (ready1) ok = 1'b1;
      tick();
    end
    valid1 = 1'b0;
  endtask

  task automatic wait_done1(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (done1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    bit bad;
    rst_n = 1'b0;
    valid1 = 1'b1;
    #12;
    vectors++;
    if ({ready1, done1, pass1, vec1, err1} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {ready1, done1, pass1, vec1, err1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ready1 !== 1'b0 || vec1 !== 16'd0) bad = 1'b1;
    end
    valid1 = 1'b0;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL no_xfer_before_start: got ready/vec activity want none");
    end
  endtask

  task automatic test_match();
    bit ok1, ok2, ok3;
    start_run1(16'd2);
    send1(8'h00, 8'h55, ok1);
    send1(8'hFF, 8'h00, ok2);
    wait_done1(ok3);
    vectors++;
    if (!(ok1 && ok2 && ok3)) begin
      miscompares++;
      $display("FAIL match_handshake: got %b%b%b want 111", ok1, ok2, ok3);
    end
    vectors++;
    if ({vec1, err1} !== {16'd2, 16'd0}) begin
      miscompares++;
      $display("FAIL match_counts: got vec=%0d err=%0d want vec=2 err=0", vec1, err1);
    end
    vectors++;
    if ({done1, pass1} !== 2'b11) begin
      miscompares++;
      $display("FAIL match_pass: got done=%b pass=%b want 1 1", done1, pass1);
    end
  endtask

  task automatic test_mismatch();
    bit ok1, ok2;
    start_run1(16'd1);
    send1(8'h01, 8'h55, ok1);
    wait_done1(ok2);
    vectors++;
    if ({ok1, ok2, vec1, err1, pass1} !== {2'b11, 16'd1, 16'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL mismatch_counts: got ok=%b%b vec=%0d err=%0d pass=%b want 11 1 1 0", ok1, ok2, vec1, err1, pass1);
    end
`ifdef CHK_FIRST_FAIL_EN
    vectors++;
    if (ff1 !== 8'h01) begin
      miscompares++;
      $display("FAIL mismatch_first_fail: got %h want 01", ff1);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] st [8] = '{8'h00, 8'hFF, 8'h01, 8'h12, 8'h34, 8'hA5, 8'h3C, 8'hE7};
    logic [7:0] rs [8] = '{8'h55, 8'h00, 8'h56, 8'h67, 8'h48, 8'hFA, 8'h40, 8'h38};
    int acc;
    bit ok;
    acc = 0;
    start_run1(16'd8);
    valid1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      stim1 = st[i];
      resp1 = rs[i];
      if (ready1) acc++;
      tick();
    end
    valid1 = 1'b0;
    vectors++;
    if (acc !== 8 || ready1 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_throughput: got %0d accepts ready=%b want 8 0", acc, ready1);
    end
    vectors++;
    if (vec1 !== 16'd6) begin
      miscompares++;
      $display("FAIL b2b_latency0: got vec=%0d want 6", vec1);
    end
    tick();
    vectors++;
    if (vec1 !== 16'd7) begin
      miscompares++;
      $display("FAIL b2b_latency1: got vec=%0d want 7", vec1);
    end
    tick();
    vectors++;
    if (vec1 !== 16'd8) begin
      miscompares++;
      $display("FAIL b2b_latency2: got vec=%0d want 8", vec1);
    end
    wait_done1(ok);
    vectors++;
    if ({ok, err1, pass1} !== {1'b1, 16'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_errors: got done=%b err=%0d pass=%b want 1 2 0", ok, err1, pass1);
    end
`ifdef CHK_FIRST_FAIL_EN
    vectors++;
    if (ff1 !== 8'h34) begin
      miscompares++;
      $display("FAIL b2b_first_fail: got %h want 34", ff1);
    end
`endif
  endtask

  task automatic test_restart_ignored();
    bit ok1, ok2, ok3;
    start_run1(16'd2);
    vectors++;
    if ({done1, pass1, vec1, err1} !== 34'd0) begin
      miscompares++;
      $display("FAIL restart_clear: got done=%b pass=%b vec=%0d err=%0d want 0", done1, pass1, vec1, err1);
    end
    send1(8'h12, 8'h67, ok1);
    num1 = 16'd5;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    send1(8'hA5, 8'hFA, ok2);
    wait_done1(ok3);
    vectors++;
    if ({ok1, ok2, ok3, vec1, err1, pass1} !== {3'b111, 16'd2, 16'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL start_in_run_ignored: got ok=%b%b%b vec=%0d err=%0d pass=%b want 111 2 0 1", ok1, ok2, ok3, vec1, err1, pass1);
    end
  endtask

  task automatic test_zero();
    start_run1(16'd0);
    valid1 = 1'b1;
    vectors++;
    if ({ready1, done1} !== 2'b00) begin
      miscompares++;
      $display("FAIL zero_run: got ready=%b done=%b want 0 0", ready1, done1);
    end
    tick();
    vectors++;
    if ({ready1, done1} !== 2'b00) begin
      miscompares++;
      $display("FAIL zero_drain: got ready=%b done=%b want 0 0", ready1, done1);
    end
    tick();
    valid1 = 1'b0;
    vectors++;
    if ({ready1, done1, pass1, vec1} !== {3'b011, 16'd0}) begin
      miscompares++;
      $display("FAIL zero_done: got ready=%b done=%b pass=%b vec=%0d want 0 1 1 0", ready1, done1, pass1, vec1);
    end
  endtask

  task automatic test_reset_midrun();
    bit ok1, ok2;
    start_run1(16'd8);
    valid1 = 1'b1;
    stim1 = 8'h01;
    resp1 = 8'h55;
    repeat (3) tick();
    valid1 = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({vec1, err1} !== {16'd3, 16'd3}) begin
      miscompares++;
      $display("FAIL midrun_counts: got vec=%0d err=%0d want 3 3", vec1, err1);
    end
`ifdef CHK_FIRST_FAIL_EN
    vectors++;
    if (ff1 !== 8'h01) begin
      miscompares++;
      $display("FAIL midrun_first_fail: got %h want 01", ff1);
    end
`endif
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ready1, done1, pass1, vec1, err1} !== 35'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %h want 0", {ready1, done1, pass1, vec1, err1});
    end
`ifdef CHK_FIRST_FAIL_EN
    vectors++;
    if (ff1 !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset_ff: got %h want 00", ff1);
    end
`endif
    valid1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    vectors++;
    if ({ready1, vec1} !== 17'd0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got ready=%b vec=%0d want 0 0", ready1, vec1);
    end
    valid1 = 1'b0;
    start_run1(16'd1);
    send1(8'h01, 8'h56, ok1);
    wait_done1(ok2);
    vectors++;
    if ({ok1, ok2, vec1, err1, pass1} !== {2'b11, 16'd1, 16'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL clean_rerun: got ok=%b%b vec=%0d err=%0d pass=%b want 11 1 0 1", ok1, ok2, vec1, err1, pass1);
    end
  endtask

  task automatic test_depth2();
    logic [7:0] rs [2] = '{8'hAA, 8'h55};
    bit ok;
    for (int r = 0; r < 2; r++) begin
      num2 = 16'd1;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      valid2 = 1'b1;
      stim2 = 8'h00;
      resp2 = rs[r];
      vectors++;
      if (ready2 !== 1'b1) begin
        miscompares++;
        $display("FAIL depth2_ready%0d: got %b want 1", r, ready2);
      end
      tick();
      valid2 = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
        if (done2) ok = 1'b1;
        else tick();
      end
      vectors++;
      if ({ok, vec2, err2, pass2} !== {1'b1, 16'd1, 16'(r), r == 0}) begin
        miscompares++;
        $display("FAIL depth2_run%0d: got done=%b vec=%0d err=%0d pass=%b want 1 1 %0d %b", r, ok, vec2, err2, pass2, r, r == 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_back_to_back();
    test_restart_ignored();
    test_zero();
    test_reset_midrun();
    test_depth2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
